// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if : host byte stream and memory write port of imem_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imem_loader_if #(
  parameter int ENTRY_WIDTH = 8,
  parameter int ADDR_WIDTH  = 14
);
  logic                   in_valid;
  logic [ENTRY_WIDTH-1:0] in_data;
  logic                   in_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [ENTRY_WIDTH-1:0] mem_wdata;
  logic                   busy;
  logic                   done;
  logic                   load_ok;

  // Host / memory / core side
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, busy, done, load_ok
  );

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, busy, done, load_ok
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader : framed byte-stream writer for the byte-wide instruction memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int              ENTRY_WIDTH = 8,
  parameter int              ADDR_WIDTH  = 14,
  parameter logic [7:0]      SYNC_BYTE   = 8'hA5
) (
  input  wire logic     clk,
  input  wire logic     rst,
  imem_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ALO  = 3'd1;
  localparam logic [2:0] S_AHI  = 3'd2;
  localparam logic [2:0] S_LLO  = 3'd3;
  localparam logic [2:0] S_LHI  = 3'd4;
  localparam logic [2:0] S_DATA = 3'd5;
  localparam logic [2:0] S_CSUM = 3'd6;
  localparam logic [2:0] S_RESP = 3'd7;

  logic [2:0]             state_q, state_d;
  logic [7:0]             addr_lo_q, addr_lo_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [ENTRY_WIDTH-1:0] csum_q, csum_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_waddr_q, mem_waddr_d;
  logic [ENTRY_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                   load_ok_q, load_ok_d;

  logic                   w_ready;
  logic                   w_fire;
  logic [15:0]            w_len;

  assign w_ready = (state_q != S_RESP);
  assign w_fire  = bus.in_valid & w_ready;
  assign w_len   = {bus.in_data, len_lo_q};

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    len_lo_d    = len_lo_q;
    csum_d      = csum_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    load_ok_d   = load_ok_q;

    case (state_q)
      S_IDLE: if (w_fire && bus.in_data == SYNC_BYTE) begin
        state_d = S_ALO;
        csum_d  = '0;
      end
      S_ALO: if (w_fire) begin
        addr_lo_d = bus.in_data;
        state_d   = S_AHI;
      end
      S_AHI: if (w_fire) begin
        // Upper address bits beyond ADDR_WIDTH are dropped.
        addr_d  = ADDR_WIDTH'({bus.in_data, addr_lo_q});
        state_d = S_LLO;
      end
      S_LLO: if (w_fire) begin
        len_lo_d = bus.in_data;
        state_d  = S_LHI;
      end
      S_LHI: if (w_fire) begin
        cnt_d   = w_len;
        state_d = (w_len == 16'd0) ? S_CSUM : S_DATA;
      end
      S_DATA: if (w_fire) begin
        csum_d      = csum_q ^ bus.in_data;
        mem_we_d    = 1'b1;
        mem_waddr_d = addr_q;
        mem_wdata_d = bus.in_data;
        addr_d      = addr_q + ADDR_WIDTH'(1);
        cnt_d       = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_CSUM;
      end
      S_CSUM: if (w_fire) begin
        load_ok_d = (bus.in_data == csum_q);
        state_d   = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_lo_q   <= '0;
      len_lo_q    <= '0;
      csum_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      load_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      len_lo_q    <= len_lo_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      load_ok_q   <= load_ok_d;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_RESP);
  assign bus.load_ok   = load_ok_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader : directed frame-level bench for imem_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerr = 0;

  imem_loader_if #(.ENTRY_WIDTH(8), .ADDR_WIDTH(14)) bus ();

  imem_loader #(.ENTRY_WIDTH(8), .ADDR_WIDTH(14), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, cleared before each frame
  logic [13:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          acc_c[$];
  int          done_cnt, rdy_low, rdy_nd;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_waddr);
      wd.push_back(bus.mem_wdata);
      wc.push_back(cyc);
    end
    if (bus.done) done_cnt++;
    if (!bus.in_ready) begin
      rdy_low++;
      if (!bus.done) rdy_nd++;
    end
  end

  logic [13:0] exp_a[$];
  logic [7:0]  exp_d[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); acc_c.delete();
    exp_a.delete(); exp_d.delete();
    done_cnt = 0; rdy_low = 0; rdy_nd = 0;
  endtask

  // Present one byte, hold until accepted, then release; returns at posedge+1
  task automatic send(input logic [7:0] b);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) begin
      nchecks++;
      nerr++;
      $error("FAIL ready_wait observed=timeout expected=accept");
    end
    acc_c.push_back(cyc);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t f, input int gap);
    foreach (f[i]) begin
      send(f[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Compare logged writes, handshake and status against the expected frame result
  task automatic check_frame(input string tag, input int pay_off, input logic exp_ok);
    check({tag, "_nwr"}, wa.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), {18'd0, wa[i]}, {18'd0, exp_a[i]});
      check($sformatf("%s_data%0d", tag, i), {24'd0, wd[i]}, {24'd0, exp_d[i]});
      if (pay_off + i < acc_c.size())
        check($sformatf("%s_wcyc%0d", tag, i), wc[i], acc_c[pay_off + i] + 1);
    end
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_rdylow"}, rdy_low, 1);
    check({tag, "_rdy_not_resp"}, rdy_nd, 0);
    check({tag, "_load_ok"}, {31'd0, bus.load_ok}, {31'd0, exp_ok});
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",    {31'd0, bus.busy},     32'd0);
    check("rst_we",      {31'd0, bus.mem_we},   32'd0);
    check("rst_done",    {31'd0, bus.done},     32'd0);
    check("rst_load_ok", {31'd0, bus.load_ok},  32'd0);
    check("rst_ready",   {31'd0, bus.in_ready}, 32'd1);
    check("rst_waddr",   {18'd0, bus.mem_waddr}, 32'd0);
    check("rst_wdata",   {24'd0, bus.mem_wdata}, 32'd0);
    @(posedge clk); #1;

    // Good frame, back-to-back
    clear_logs();
    exp_a = '{14'h0000, 14'h0001, 14'h0002, 14'h0003};
    exp_d = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, 0);
    settle(2);
    check("good_b2b", wc.size() == 4 ? wc[3] - wc[0] : -1, 3);
    check_frame("good", 5, 1'b1);

    // Bad checksum: writes still committed
    clear_logs();
    exp_a = '{14'h0000, 14'h0001, 14'h0002, 14'h0003};
    exp_d = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12}, 0);
    settle(2);
    check_frame("badcs", 5, 1'b0);

    // Address wrap at the top of a 14-bit space
    clear_logs();
    exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame('{8'hA5, 8'hFE, 8'h3F, 8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, 0);
    settle(2);
    check_frame("wrap", 5, 1'b1);

    // Bad frame to drive load_ok low again
    clear_logs();
    send_frame('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h77}, 0);
    settle(2);
    check_frame("zerobad", 5, 1'b0);

    // Leading garbage, then a zero-length frame
    clear_logs();
    send_frame('{8'h00, 8'hFF, 8'h5A}, 0);
    @(negedge clk);
    check("garbage_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    send_frame('{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    settle(2);
    check_frame("zerolen", 8, 1'b1);

    // Gapped stream: in_valid toggles every cycle
    clear_logs();
    exp_a = '{14'h0000, 14'h0001, 14'h0002, 14'h0003};
    exp_d = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, 1);
    settle(2);
    check("gap_spacing", wc.size() == 4 ? wc[1] - wc[0] : -1, 2);
    check_frame("gapped", 5, 1'b1);

    // Reset after two payload bytes, with a byte offered in the reset cycle
    clear_logs();
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00}, 0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {31'd0, bus.busy},   32'd0);
    check("rstmid_we",   {31'd0, bus.mem_we}, 32'd0);
    settle(3);
    check("rstmid_nwr",   wa.size(), 2);
    check("rstmid_addr1", wa.size() == 2 ? {18'd0, wa[1]} : 32'hFFFF, 32'h1);
    check("rstmid_busy2", {31'd0, bus.busy}, 32'd0);
    check("rstmid_load_ok", {31'd0, bus.load_ok}, 32'd0);

    clear_logs();
    exp_a = '{14'h0000, 14'h0001, 14'h0002, 14'h0003};
    exp_d = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, 0);
    settle(2);
    check_frame("postrst", 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

`default_nettype wire
